trace_capture_fifo: RTL
=======================

Name: trace_capture_fifo

Overview:
- Debug trace buffer downstream of the single-cycle core (`risc5`).
- Samples the core's per-cycle execution record: PC, instruction word, write-back data and control flags.
- Begins capture when the PC matches a programmable trigger address, stores records in a FIFO, and drains them through a valid/ready read port.
- Runs on the core clock alongside the processor; capture never stalls the core.

Parameters:
- DEPTH, 16, number of record entries; must be a power of two, ≥2.
- AW, 4, log2(DEPTH); pointer width.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- arm  input  1  one-cycle request to flush the FIFO and wait for the trigger.
- trig_pc  input  32  PC value that starts capture.
- stop_on_full  input  1  1: freeze when full; 0: drop new records when full.
- pc_in  input  32  core PC this cycle.
- instr_in  input  32  core instruction word this cycle.
- wb_data_in  input  32  core write-back mux output this cycle.
- reg_write_in  input  1  core register-file write enable.
- mem_write_in  input  1  core data-memory write enable.
- rd_ready  input  1  consumer accepts the head record.
- rd_valid  output  1  head record present.
- rd_pc  output  32  head record PC.
- rd_instr  output  32  head record instruction.
- rd_wb_data  output  32  head record write-back data.
- rd_flags  output  2  head record {mem_write, reg_write}.
- count  output  AW+1  entries currently stored, 0..DEPTH.
- drop_cnt  output  16  records lost while full; saturating.
- state_out  output  2  FSM state encoding.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE; pointers, count and drop_cnt clear to 0.
  - rd_valid=0 and all rd_* fields read 0.
  - Reset takes effect immediately mid-capture; stored records are lost.
- Record format: {pc_in, instr_in, wb_data_in, mem_write_in, reg_write_in}, sampled at the rising edge.
- FSM states (state_out): IDLE=0, ARMED=1, CAPTURE=2, FROZEN=3.
  - IDLE: no writes. arm=1 → ARMED.
  - ARMED:
    - pc_in==trig_pc → write this cycle's record, go to CAPTURE.
    - Otherwise no write.
    - arm is ignored.
  - CAPTURE: attempt a write every cycle; arm is ignored.
    - Not full, or full with a pop in the same cycle → write accepted.
    - Full, no pop, stop_on_full=1 → no write, go to FROZEN, drop_cnt unchanged.
    - Full, no pop, stop_on_full=0 → record discarded, drop_cnt+1 saturating at 0xFFFF, stay in CAPTURE.
  - FROZEN: no writes; reads continue. arm=1 → ARMED.
- arm accepted (IDLE or FROZEN):
  - Flushes pointers, count and drop_cnt to 0 on the same edge.
  - Flush overrides any simultaneous pop.
  - A trigger match cannot occur on the arm cycle itself; matching begins the following cycle.
- Read port (show-ahead):
  - rd_valid = (count != 0); rd_* always reflect the head entry.
  - Pop occurs when rd_valid && rd_ready, in any state.
  - rd_ready with rd_valid=0 has no effect.
  - When rd_valid=0, rd_* hold their last values; the consumer must not use them.
- Latency:
  - A record written at edge k is visible on rd_* after edge k when the FIFO was empty.
  - count updates on the same edge as the write/pop.
  - Push and pop in the same cycle leave count unchanged.
- Pointers are AW bits and wrap modulo DEPTH; full is count==DEPTH; count is never allowed to exceed DEPTH.
- trig_pc and stop_on_full are sampled every cycle; changing them mid-capture takes effect on the next edge.

Test Plan:
- Trigger capture: arm, then trig_pc=0x8 with PC sequence 0x0,0x4,0x8,0xC,0x10, no reads → count=3; pops yield rd_pc 0x8, 0xC, 0x10 in order with matching instr/flags; state_out=2.
- Freeze on full: stop_on_full=1, trigger, 20 cycles with no reads → count=16, state_out=3 after the 17th capture cycle, drop_cnt=0, head rd_pc = trigger PC.
- Drop on full: stop_on_full=0, trigger, 20 cycles with no reads → count=16, drop_cnt=4, state stays 2; entries are the first 16 records after the trigger.
- Full with concurrent pop: FIFO full in CAPTURE, rd_ready=1 for 3 cycles → count stays 16, drop_cnt=0, oldest 3 records removed, newest 3 appended.
- Re-arm from FROZEN with count=16 and drop_cnt=5: pulse arm with rd_ready=1 → next cycle count=0, drop_cnt=0, rd_valid=0, state_out=1.
- Reset mid-capture: count=7 in CAPTURE, drive reset=0 between edges → outputs zero immediately (count=0, rd_valid=0, state_out=0); after release, no capture until arm.

Source files
------------

// File: rtl/trace_capture_fifo.sv
// Debug trace buffer: captures per-cycle core execution records once the PC hits a
// trigger address, and drains them through a show-ahead valid/ready read port.
package trace_capture_fifo_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] wb_data;
        logic        mem_write;
        logic        reg_write;
    } trace_rec_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        FROZEN  = 2'd3
    } trace_state_t;

endpackage

module trace_capture_fifo
    import trace_capture_fifo_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          arm,
    input  logic [31:0]   trig_pc,
    input  logic          stop_on_full,
    input  logic [31:0]   pc_in,
    input  logic [31:0]   instr_in,
    input  logic [31:0]   wb_data_in,
    input  logic          reg_write_in,
    input  logic          mem_write_in,
    input  logic          rd_ready,
    output logic          rd_valid,
    output logic [31:0]   rd_pc,
    output logic [31:0]   rd_instr,
    output logic [31:0]   rd_wb_data,
    output logic [1:0]    rd_flags,
    output logic [AW:0]   count,
    output logic [15:0]   drop_cnt,
    output logic [1:0]    state_out
);

    localparam int unsigned   CW         = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [15:0]   DROP_MAX   = 16'hFFFF;

    trace_state_t  state, next_state;
    trace_rec_t    mem [DEPTH];
    trace_rec_t    wr_rec;
    trace_rec_t    head_next;
    trace_rec_t    head_q;
    logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_next;
    logic [CW-1:0] count_q, count_next;
    logic [15:0]   drop_q;
    logic          valid_q;
    logic          full, pop, push, flush, drop_inc;

    assign full = (count_q == FULL_COUNT);
    assign pop  = valid_q && rd_ready;

    // Next-state and write/flush/drop decisions
    always_comb begin
        next_state = state;
        push       = 1'b0;
        flush      = 1'b0;
        drop_inc   = 1'b0;
        case (state)
            IDLE, FROZEN: begin
                if (arm) begin
                    flush      = 1'b1;
                    next_state = ARMED;
                end
            end
            ARMED: begin
                if (pc_in == trig_pc) begin
                    push       = 1'b1;
                    next_state = CAPTURE;
                end
            end
            CAPTURE: begin
                if (!full || pop) begin
                    push = 1'b1;
                end else if (stop_on_full) begin
                    next_state = FROZEN;
                end else begin
                    drop_inc = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Pointer/occupancy update and the head entry to present after this edge
    always_comb begin
        wr_rec      = {pc_in, instr_in, wb_data_in, mem_write_in, reg_write_in};
        rd_ptr_next = rd_ptr;
        count_next  = count_q;
        if (flush) begin
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (pop) begin
                rd_ptr_next = rd_ptr + AW'(1);
            end
            count_next = count_q + CW'(push) - CW'(pop);
        end
        // A lone surviving entry that is being written now is not in mem yet
        head_next = (push && (count_next == CW'(1))) ? wr_rec : mem[rd_ptr_next];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            drop_q  <= '0;
            valid_q <= 1'b0;
            head_q  <= '0;
        end else begin
            state   <= next_state;
            rd_ptr  <= rd_ptr_next;
            count_q <= count_next;
            valid_q <= (count_next != '0);
            if (flush) begin
                wr_ptr <= '0;
            end else if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (flush) begin
                drop_q <= '0;
            end else if (drop_inc && (drop_q != DROP_MAX)) begin
                drop_q <= drop_q + 16'd1;
            end
            // Outputs keep their last head when the buffer goes empty
            if (count_next != '0) begin
                head_q <= head_next;
            end
        end
    end

    // Record storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_rec;
        end
    end

    assign rd_valid   = valid_q;
    assign rd_pc      = head_q.pc;
    assign rd_instr   = head_q.instr;
    assign rd_wb_data = head_q.wb_data;
    assign rd_flags   = {head_q.mem_write, head_q.reg_write};
    assign count      = count_q;
    assign drop_cnt   = drop_q;
    assign state_out  = state;

endmodule
